// File: rtl/scanline_bank_sequencer.sv
// rtl/scanline_bank_sequencer.sv - PPU scanline tracker, split-table CHR bank sequencer and scanline IRQ
// Optional feature macro: SBS_SPRITE_BANK_EN (sprite-fetch CHR bank override).
module scanline_bank_sequencer #(
  parameter int BANK_W      = 2,
  parameter int SPLITS      = 4,
  parameter int LINE_W      = 8,
  parameter int SWITCH_TILE = 40,
  parameter int MATCH_READS = 3,
  parameter int IDLE_CLKS   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ppu_rd,
  input  logic [13:0]       ppu_addr,
  input  logic              frame_end,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [BANK_W-1:0] chr_bank,
  output logic [LINE_W-1:0] scanline,
  output logic              in_frame,
  output logic              irq
);

  localparam int MW = $clog2(MATCH_READS + 1);
  localparam int IW = $clog2(IDLE_CLKS + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(MATCH_READS);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CLKS);
  localparam logic [5:0]    SWITCH_T  = 6'(SWITCH_TILE);

  logic              rd_meta_q, rd_sync_q, rd_prev_q;
  logic [13:0]       addr_meta_q, addr_sync_q;
  logic [13:0]       prev_addr_q, prev_addr_d;
  logic [MW-1:0]     match_q, match_d;
  logic [5:0]        tile_q, tile_d;
  logic [LINE_W-1:0] scanline_q, scanline_d;
  logic              in_frame_q, in_frame_d;
  logic              irq_q, irq_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [IW-1:0]     idle_q, idle_d;

  logic [BANK_W-1:0] base_bank_q, base_bank_d;
  logic [LINE_W-1:0] irq_line_q, irq_line_d;
  logic              irq_en_q, irq_en_d;
  logic [LINE_W-1:0] split_line_q [SPLITS];
  logic [LINE_W-1:0] split_line_d [SPLITS];
  logic              split_en_q   [SPLITS];
  logic              split_en_d   [SPLITS];
  logic [BANK_W-1:0] split_bank_q [SPLITS];
  logic [BANK_W-1:0] split_bank_d [SPLITS];
`ifdef SBS_SPRITE_BANK_EN
  logic [BANK_W-1:0] spr_bank_q, spr_bank_d;
`endif

  logic              rd_evt, cur_nt, line_evt, idle_end, fend;
  logic              pat_to_nt, nt_to_pat, hit, irq_set, irq_ack;
  logic [13:0]       cur_addr;
  logic [MW-1:0]     match_inc;
  logic [LINE_W-1:0] new_line;
  logic [LINE_W:0]   next_line;
  logic [BANK_W-1:0] hit_bank;

  always_comb begin
    rd_evt    = rd_prev_q & ~rd_sync_q;
    cur_addr  = addr_sync_q;
    cur_nt    = (cur_addr[13:12] == 2'b10);
    match_inc = match_q + 1'b1;
    pat_to_nt = rd_evt & ~prev_addr_q[13] & cur_addr[13];
    nt_to_pat = rd_evt & prev_addr_q[13] & ~cur_addr[13];
    next_line = {1'b0, scanline_q} + 1'b1;

    line_evt = 1'b0;
    match_d  = match_q;
    if (rd_evt) begin
      if (cur_nt && (cur_addr == prev_addr_q)) begin
        if (match_inc == MATCH_MAX) begin
          line_evt = 1'b1;
          match_d  = '0;
        end else begin
          match_d = match_inc;
        end
      end else begin
        match_d = MW'(cur_nt);
      end
    end

    // Idle timeout fires once when the count reaches IDLE_CLKS, then holds.
    idle_end = ~rd_evt & (idle_q == IDLE_MAX - 1'b1);
    if (rd_evt)                idle_d = '0;
    else if (idle_q == IDLE_MAX) idle_d = idle_q;
    else                       idle_d = idle_q + 1'b1;
    fend = frame_end | idle_end;

    prev_addr_d = rd_evt ? cur_addr : prev_addr_q;

    hit      = 1'b0;
    hit_bank = '0;
    for (int i = SPLITS - 1; i >= 0; i--) begin
      if (split_en_q[i] && ({1'b0, split_line_q[i]} == next_line)) begin
        hit      = 1'b1;
        hit_bank = split_bank_q[i];
      end
    end

    new_line = in_frame_q ? ((scanline_q == '1) ? scanline_q : next_line[LINE_W-1:0]) : '0;

    in_frame_d = in_frame_q;
    scanline_d = scanline_q;
    tile_d     = tile_q;
    bank_d     = bank_q;
    if (fend) begin
      in_frame_d = 1'b0;
      scanline_d = '0;
      tile_d     = '0;
      match_d    = '0;
      bank_d     = base_bank_q;
    end else begin
      if (line_evt) begin
        in_frame_d = 1'b1;
        scanline_d = new_line;
        tile_d     = '0;
      end else if (nt_to_pat && (tile_q != 6'd63)) begin
        tile_d = tile_q + 6'd1;
      end
      if (pat_to_nt && (tile_q == SWITCH_T) && hit) bank_d = hit_bank;
    end

    irq_set = line_evt & ~fend & irq_en_q & (new_line == irq_line_q);
    irq_ack = cfg_we & (cfg_addr == 4'd2) & cfg_wdata[1];
    if (irq_set)                  irq_d = 1'b1;
    else if (irq_ack || !irq_en_q) irq_d = 1'b0;
    else                          irq_d = irq_q;

    base_bank_d  = base_bank_q;
    irq_line_d   = irq_line_q;
    irq_en_d     = irq_en_q;
    split_line_d = split_line_q;
    split_en_d   = split_en_q;
    split_bank_d = split_bank_q;
`ifdef SBS_SPRITE_BANK_EN
    spr_bank_d   = spr_bank_q;
`endif
    if (cfg_we) begin
      case (cfg_addr)
        4'd0: base_bank_d = cfg_wdata[BANK_W-1:0];
        4'd1: irq_line_d  = cfg_wdata[LINE_W-1:0];
        4'd2: irq_en_d    = cfg_wdata[0];
        4'd3: begin
`ifdef SBS_SPRITE_BANK_EN
          spr_bank_d = cfg_wdata[BANK_W-1:0];
`endif
        end
        default: begin
          for (int i = 0; i < SPLITS; i++) begin
            if (cfg_addr == 4'(4 + 2 * i)) split_line_d[i] = cfg_wdata[LINE_W-1:0];
            if (cfg_addr == 4'(5 + 2 * i)) begin
              split_en_d[i]   = cfg_wdata[7];
              split_bank_d[i] = cfg_wdata[BANK_W-1:0];
            end
          end
        end
      endcase
    end
  end

  // /RD idles high, so the synchroniser resets high to avoid a phantom read edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_meta_q   <= 1'b1;
      rd_sync_q   <= 1'b1;
      rd_prev_q   <= 1'b1;
      addr_meta_q <= '0;
      addr_sync_q <= '0;
      prev_addr_q <= '0;
      match_q     <= '0;
      tile_q      <= '0;
      scanline_q  <= '0;
      in_frame_q  <= 1'b0;
      irq_q       <= 1'b0;
      bank_q      <= '0;
      idle_q      <= '0;
      base_bank_q <= '0;
      irq_line_q  <= '0;
      irq_en_q    <= 1'b0;
      for (int i = 0; i < SPLITS; i++) begin
        split_line_q[i] <= '0;
        split_en_q[i]   <= 1'b0;
        split_bank_q[i] <= '0;
      end
`ifdef SBS_SPRITE_BANK_EN
      spr_bank_q  <= '0;
`endif
    end else begin
      rd_meta_q   <= ppu_rd;
      rd_sync_q   <= rd_meta_q;
      rd_prev_q   <= rd_sync_q;
      addr_meta_q <= ppu_addr;
      addr_sync_q <= addr_meta_q;
      prev_addr_q <= prev_addr_d;
      match_q     <= match_d;
      tile_q      <= tile_d;
      scanline_q  <= scanline_d;
      in_frame_q  <= in_frame_d;
      irq_q       <= irq_d;
      bank_q      <= bank_d;
      idle_q      <= idle_d;
      base_bank_q <= base_bank_d;
      irq_line_q  <= irq_line_d;
      irq_en_q    <= irq_en_d;
      split_line_q <= split_line_d;
      split_en_q   <= split_en_d;
      split_bank_q <= split_bank_d;
`ifdef SBS_SPRITE_BANK_EN
      spr_bank_q  <= spr_bank_d;
`endif
    end
  end

`ifdef SBS_SPRITE_BANK_EN
  assign chr_bank = (in_frame_q && (tile_q >= 6'd32) && (tile_q <= 6'd39)) ? spr_bank_q : bank_q;
`else
  assign chr_bank = bank_q;
`endif
  assign scanline = scanline_q;
  assign in_frame = in_frame_q;
  assign irq      = irq_q;

endmodule
